// File: rtl/jk_excitation_driver_if.sv
// Target-bit stream into the JK excitation driver: valid/ready handshake carrying one bit.
// tgt_ready is a pure function of FIFO occupancy, so the source may hold tgt_valid indefinitely.
interface jk_excitation_driver_if;
    logic tgt_valid;
    logic tgt_bit;
    logic tgt_ready;

    modport master (output tgt_valid, output tgt_bit, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_bit, output tgt_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// Translates buffered target bits into registered J/K via the excitation table and checks the flop's Q back.
// Push-to-J/K one cycle minimum, Q compared two edges after the pop; tgt_ready drops when the FIFO holds DEPTH bits.
module jk_excitation_driver #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter bit DC_FILL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_excitation_driver_if.slave tgt,
    input  logic                 q_fb,
    input  logic                 resync,
    output logic                 J,
    output logic                 K,
    output logic                 busy,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     err_count
);
    localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic model;
    logic exc_vld;
    logic exc_exp;
    logic chk_valid;
    logic chk_exp;

    logic do_push;
    logic do_pop;
    logic head;
    logic j_nxt;
    logic k_nxt;

    assign tgt.tgt_ready = (count < FULL);
    assign do_push       = tgt.tgt_valid & tgt.tgt_ready;
    // A resync edge freezes the FIFO so the reloaded model sees the same head next cycle.
    assign do_pop        = (count != '0) & ~resync;
    assign head          = mem[rd_ptr];
    assign busy          = (count != '0) | exc_vld | chk_valid;

    always_comb begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (do_pop) begin
            if (!model) begin
                j_nxt = head;
                k_nxt = DC_FILL;
            end else begin
                j_nxt = DC_FILL;
                k_nxt = ~head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= tgt.tgt_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            J         <= 1'b0;
            K         <= 1'b0;
            model     <= 1'b0;
            exc_vld   <= 1'b0;
            exc_exp   <= 1'b0;
            chk_valid <= 1'b0;
            chk_exp   <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            J        <= j_nxt;
            K        <= k_nxt;
            mismatch <= 1'b0;

            if (resync) begin
                model     <= q_fb;
                exc_vld   <= 1'b0;
                chk_valid <= 1'b0;
            end else begin
                if (do_pop) begin
                    model <= head;
                end
                // exc_* covers the edge where the flop samples J/K; chk_* lines up with the settled Q.
                exc_vld   <= do_pop;
                exc_exp   <= head;
                chk_valid <= exc_vld;
                chk_exp   <= exc_exp;
                if (chk_valid && (q_fb != chk_exp)) begin
                    mismatch <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: an ideal JK flop closes the loop, a target-bit scoreboard predicts J/K per pop.
module tb_jk_excitation_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic       resync;
    logic       stuck;
    logic       q_load;
    logic       q_load_val;
    logic       q  = 1'b0;
    logic       q2 = 1'b0;
    logic       q_fb;
    logic       q_fb2;
    logic       J, K, busy, mismatch;
    logic [7:0] err_count;
    logic       J2, K2, busy2, mismatch2;
    logic [7:0] err_count2;

    int checks = 0;
    int errors = 0;
    int mm_cnt = 0;
    int mm2_cnt = 0;
    bit mon_en = 1'b0;
    bit sb_q[$];
    bit exp_model = 1'b0;

    jk_excitation_driver_if a();
    jk_excitation_driver_if b();

    always #5 clk = ~clk;

    assign q_fb  = stuck ? 1'b0 : q;
    assign q_fb2 = q2;

    jk_excitation_driver #(.DEPTH(4), .CNT_W(8), .DC_FILL(1'b0)) dut (
        .clk(clk), .rst(rst), .tgt(a.slave), .q_fb(q_fb), .resync(resync),
        .J(J), .K(K), .busy(busy), .mismatch(mismatch), .err_count(err_count)
    );

    jk_excitation_driver #(.DEPTH(4), .CNT_W(8), .DC_FILL(1'b1)) dut_dc1 (
        .clk(clk), .rst(rst), .tgt(b.slave), .q_fb(q_fb2), .resync(1'b0),
        .J(J2), .K(K2), .busy(busy2), .mismatch(mismatch2), .err_count(err_count2)
    );

    // External JK flops: Q+ = J&~Q | ~K&Q, with a bench-side load to force Q.
    always @(posedge clk) begin
        if (q_load) q <= q_load_val;
        else        q <= (J & ~q) | (~K & q);
        q2 <= (J2 & ~q2) | (~K2 & q2);
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: accepted bits queue up, each pop predicts J/K from the bench's own state model.
    always @(posedge clk) begin
        bit acc, pop_e, t, ej, ek;
        acc   = a.tgt_valid && a.tgt_ready;
        pop_e = !rst && !resync && (sb_q.size() != 0);
        ej = 1'b0;
        ek = 1'b0;
        if (rst) begin
            sb_q.delete();
            exp_model = 1'b0;
        end else begin
            if (resync) exp_model = q_fb;
            if (pop_e) begin
                t = sb_q.pop_front();
                if (!exp_model) begin ej = t;    ek = 1'b0; end
                else            begin ej = 1'b0; ek = !t;   end
                exp_model = t;
            end
            if (acc) sb_q.push_back(a.tgt_bit);
        end
        #1;
        if (mismatch)  mm_cnt++;
        if (mismatch2) mm2_cnt++;
        if (mon_en) begin
            check("sb_J", J, ej);
            check("sb_K", K, ek);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_bit(input bit v);
        int n = 0;
        a.tgt_valid = 1'b1;
        a.tgt_bit   = v;
        while (!a.tgt_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("push_timeout", 0, 1);
            a.tgt_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        a.tgt_valid = 1'b0;
        while ((busy || busy2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", int'(busy || busy2), 0);
    endtask

    task automatic push_dc1(input bit v);
        b.tgt_valid = 1'b1;
        b.tgt_bit   = v;
        @(negedge clk);
        b.tgt_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int mm0;
        rst = 1'b1; resync = 1'b0; stuck = 1'b0; q_load = 1'b0; q_load_val = 1'b0;
        a.tgt_valid = 1'b0; a.tgt_bit = 1'b0;
        b.tgt_valid = 1'b0; b.tgt_bit = 1'b0;
        cycles(3);
        rst = 1'b0;
        check("rst_ready", a.tgt_ready, 1);
        check("rst_J", J, 0);
        check("rst_K", K, 0);
        check("rst_busy", busy, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_err", err_count, 0);
        check("rst_ready2", b.tgt_ready, 1);
        mon_en = 1'b1;

        // Ideal loop: J/K follow the excitation table, Q tracks the targets.
        mm0 = mm_cnt;
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
        drain();
        check("t1_q", q_fb, 1);
        check("t1_mm", mm_cnt - mm0, 0);
        check("t1_err", err_count, 0);

        // Resync held high stalls pops: fill, back-pressure, then drain across the pointer wrap.
        mm0 = mm_cnt;
        resync = 1'b1;
        fork
            begin
                push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
                a.tgt_valid = 1'b0;
            end
            begin
                cycles(8);
                check("t2_full_ready", a.tgt_ready, 0);
                check("t2_busy", busy, 1);
                resync = 1'b0;
            end
        join
        drain();
        check("t2_mm", mm_cnt - mm0, 0);
        check("t2_err", err_count, 0);

        // Q stuck at 0: mismatch lands two edges after the pop, then the counter saturates.
        stuck = 1'b1;
        mm0 = mm_cnt;
        push_bit(1'b1);
        a.tgt_valid = 1'b0;
        @(negedge clk); check("t3_J_pop", J, 1); check("t3_mm_n", mismatch, 0);
        @(negedge clk); check("t3_mm_n1", mismatch, 0);
        @(negedge clk); check("t3_mm_n2", mismatch, 1); check("t3_err1", err_count, 1);
        @(negedge clk); check("t3_mm_n3", mismatch, 0);
        repeat (255) push_bit(1'b1);
        drain();
        check("t3_sat", err_count, 255);
        check("t3_pulses", mm_cnt - mm0, 256);
        stuck = 1'b0;

        // Resync reloads the model from an externally forced Q=1.
        mm0 = mm_cnt;
        push_bit(1'b0);
        drain();
        q_load = 1'b1; q_load_val = 1'b1;
        @(negedge clk);
        q_load = 1'b0;
        check("t4_qfb", q_fb, 1);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        push_bit(1'b0);
        a.tgt_valid = 1'b0;
        @(negedge clk);
        check("t4_J", J, 0);
        check("t4_K", K, 1);
        drain();
        check("t4_mm", mm_cnt - mm0, 0);
        check("t4_err", err_count, 255);

        // Reset with three bits queued and a failing check in flight.
        stuck = 1'b1;
        resync = 1'b1;
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
        a.tgt_valid = 1'b0;
        resync = 1'b0;
        @(negedge clk);
        check("t5_busy_pre", busy, 1);
        mm0 = mm_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", a.tgt_ready, 1);
        check("t5_J", J, 0);
        check("t5_K", K, 0);
        check("t5_busy", busy, 0);
        check("t5_mismatch", mismatch, 0);
        check("t5_err", err_count, 0);
        cycles(3);
        check("t5_mm", mm_cnt - mm0, 0);
        stuck = 1'b0;
        q_load = 1'b1; q_load_val = 1'b0;
        @(negedge clk);
        q_load = 1'b0;

        // DC_FILL=1 instance: don't-care side driven high, flop still lands on target.
        mm0 = mm2_cnt;
        push_dc1(1'b0);
        check("t6_J_0", J2, 0);
        check("t6_K_0", K2, 1);
        cycles(3);
        check("t6_q_0", q_fb2, 0);
        push_dc1(1'b1);
        check("t6_J_01", J2, 1);
        check("t6_K_01", K2, 1);
        cycles(3);
        check("t6_q_1", q_fb2, 1);
        push_dc1(1'b0);
        check("t6_J_10", J2, 1);
        check("t6_K_10", K2, 1);
        cycles(3);
        check("t6_q_10", q_fb2, 0);
        check("t6_mm", mm2_cnt - mm0, 0);
        check("t6_err", err_count2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives the J/K inputs of an external JK flip-flop so that its Q output follows a stream of target next-state bits.
- Target bits arrive over a valid/ready handshake and are buffered in a small FIFO.
- Each target bit is translated to J/K with the JK excitation table. The flop's Q is then sampled back and checked against the expected value.
- The block sits in front of the JK flip-flop as its stimulus and self-check driver.

Parameters:
- DEPTH, 4, target FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the mismatch counter.
- DC_FILL, 0, value driven on the don't-care input (K when model=0, J when model=1).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target bit offered.
- tgt_bit  input  1  desired next Q value.
- tgt_ready  output  1  FIFO can accept; high when count < DEPTH.
- q_fb  input  1  Q of the driven JK flop.
- resync  input  1  one-cycle request to reload the model state from q_fb.
- J  output  1  registered J to the flop.
- K  output  1  registered K to the flop.
- busy  output  1  FIFO non-empty or a check is pending.
- mismatch  output  1  one-cycle pulse on a failed check.
- err_count  output  CNT_W  saturating count of mismatches.

Behaviour:
- **Reset:** one clock; the reset is synchronous and active-high. On reset, FIFO empty, tgt_ready=1, J=0, K=0, model=0, chk_valid=0, mismatch=0, err_count=0, busy=0. Model=0 matches the flop's power-up Q=0.
- **Reset mid-operation:** flushes all FIFO entries and pending checks, with no mismatch reported.
- **Push:** tgt_valid & tgt_ready at an edge writes tgt_bit at the write pointer.
- **Pop:** at every edge where the FIFO is non-empty, pop the head.
- **Simultaneous push/pop:** allowed; the count is unchanged. A push when full is ignored because tgt_ready=0.
- **Pointer wrap:** modulo DEPTH.
- **Full/empty:** both are derived from a count register of width log2(DEPTH)+1.
- **Excitation on pop,** with m = model and t = head, giving registered J,K:
  - m=0, t=0 -> J=0, K=DC_FILL
  - m=0, t=1 -> J=1, K=DC_FILL
  - m=1, t=1 -> J=DC_FILL, K=0
  - m=1, t=0 -> J=DC_FILL, K=1
  - In the same edge: model <= t, chk_exp <= t.
- **Idle:** on an edge with an empty FIFO, J<=0, K<=0 (hold) and model is unchanged.
- **Timing / latency:**
  - Edge n: pop and register J/K.
  - Edge n+1: the flop updates Q; chk_valid <= 1 and chk_exp is staged.
  - Edge n+2: compare q_fb with the staged chk_exp.
  - Push to J/K visible is 1 cycle minimum (FIFO empty, push at edge p, pop at edge p+1).
  - Back-to-back pops pipeline with one check per cycle.
- **Check:** if q_fb != chk_exp at the compare edge, mismatch=1 for one cycle and err_count increments. err_count saturates at 2^CNT_W-1. The model is not corrected automatically.
- **Resync:** at that edge, model <= q_fb, and all in-flight checks (stages n+1 and n+2) are discarded with no mismatch. Any pop at that same edge is suppressed, so FIFO contents are retained. Resync has priority over pop.
- **busy:** busy = (count != 0) | check pipeline valid.

Test Plan:
- Reset, then push 1,1,0,0,1 back-to-back with an ideal JK model on q_fb -> J,K sequence (1,0),(0,0),(0,1),(0,0),(1,0) with DC_FILL=0; Q follows 1,1,0,0,1; mismatch never asserted; err_count=0.
- Push 5 bits with DEPTH=4 while pops are stalled by holding resync high -> tgt_ready=0 after 4 accepts; 5th held until resync drops, then accepted. FIFO order preserved across pointer wrap.
- Force q_fb stuck at 0, push 1 -> mismatch pulses exactly at edge n+2; err_count=1. Push 255 more 1s with CNT_W=8 -> err_count saturates at 255.
- Set q_fb=1 externally, pulse resync, push 0 -> model=1 so J=DC_FILL, K=1; no mismatch from the resync.
- Assert rst while 3 entries are queued and a check is pending -> next cycle FIFO empty, J=K=0, no mismatch pulse, err_count=0.
- Rebuild with DC_FILL=1, push 0 from model=0 -> J=0, K=1; the flop still resets, check passes.
